// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU-side memory controller for a Game Boy style system.
// Decodes the internal registers (HRAM, IF, IE, DMA, BOOT), forwards all
// other CPU accesses to the external memory bus, and runs the OAM DMA engine
// that copies 160 bytes from {src,00}..{src,9F} into OAM.
//
// Handshake: there is no valid/ready pair here. Every CPU access is qualified
// by mclk_in; an access is "presented" on a clk_in edge where mclk_in=1, the
// write commits on that edge and the read byte appears on cpu_rdata after it.
// External and OAM write strobes are combinational and are one clk_in wide
// because mclk_in itself is one clk_in wide.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mclk_in,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] ext_addr,
  input  logic [7:0]  ext_rdata,
  output logic [7:0]  ext_wdata,
  output logic        ext_write,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_write,
  input  logic [4:0]  irq_req,
  output logic [7:0]  ie_out,
  output logic [4:0]  if_out,
  output logic        dma_active,
  output logic        boot_en,
  output logic [1:0]  dma_state
);

  typedef enum logic [1:0] {
    DMA_IDLE   = 2'd0,
    DMA_START  = 2'd1,
    DMA_ACTIVE = 2'd2
  } dma_state_t;

  localparam logic [7:0] LAST_INDEX = 8'd159;

  // Registers
  logic [7:0]  r_rdata;
  logic [4:0]  r_if;
  logic [7:0]  r_ie;
  logic [7:0]  r_dma_src;
  logic        r_boot_en;
  dma_state_t  r_state;
  logic [7:0]  r_index;
  logic [7:0]  r_hram [0:126];

  // Combinational signals
  dma_state_t  w_state_nxt;
  logic [7:0]  w_index_nxt;
  logic        w_sel_hram;
  logic        w_sel_if;
  logic        w_sel_dma;
  logic        w_sel_boot;
  logic        w_sel_ie;
  logic        w_sel_ext;
  logic        w_cpu_wr;
  logic        w_dma_busy;
  logic [7:0]  w_rd_byte;

  // Address decode of the internal register space
  always_comb begin
    w_sel_hram = (cpu_addr[15:7] == 9'h1FF) && (cpu_addr[6:0] != 7'h7F);
    w_sel_if   = (cpu_addr == 16'hFF0F);
    w_sel_dma  = (cpu_addr == 16'hFF46);
    w_sel_boot = (cpu_addr == 16'hFF50);
    w_sel_ie   = (cpu_addr == 16'hFFFF);
    w_sel_ext  = !(w_sel_hram || w_sel_if || w_sel_dma || w_sel_boot || w_sel_ie);
    w_cpu_wr   = cpu_write && mclk_in;
    w_dma_busy = (r_state == DMA_ACTIVE);
  end

  // Read byte selection; the external bus belongs to DMA while it is active
  always_comb begin
    w_rd_byte = 8'hFF;
    if (w_sel_hram) begin
      w_rd_byte = r_hram[cpu_addr[6:0]];
    end else if (w_sel_if) begin
      w_rd_byte = {3'b111, r_if};
    end else if (w_sel_dma) begin
      w_rd_byte = r_dma_src;
    end else if (w_sel_boot) begin
      w_rd_byte = 8'hFF;
    end else if (w_sel_ie) begin
      w_rd_byte = r_ie;
    end else if (!w_dma_busy) begin
      w_rd_byte = ext_rdata;
    end
  end

  // DMA next-state logic; a write to FF46 restarts from any state
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    case (r_state)
      DMA_IDLE: begin
        w_state_nxt = DMA_IDLE;
      end
      DMA_START: begin
        if (mclk_in) begin
          w_state_nxt = DMA_ACTIVE;
          w_index_nxt = 8'd0;
        end
      end
      DMA_ACTIVE: begin
        if (mclk_in) begin
          if (r_index == LAST_INDEX) begin
            w_state_nxt = DMA_IDLE;
            w_index_nxt = 8'd0;
          end else begin
            w_index_nxt = r_index + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = DMA_IDLE;
        w_index_nxt = 8'd0;
      end
    endcase
    if (w_cpu_wr && w_sel_dma) begin
      w_state_nxt = DMA_START;
      w_index_nxt = 8'd0;
    end
  end

  // DMA state and transfer index registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= DMA_IDLE;
      r_index <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
    end
  end

  // Registered CPU read data, loaded once per M-cycle
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rdata <= 8'hFF;
    end else if (mclk_in) begin
      r_rdata <= w_rd_byte;
    end
  end

  // Interrupt flags: incoming requests are OR'd after the CPU write so they win
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_if <= 5'd0;
    end else begin
      r_if <= ((w_cpu_wr && w_sel_if) ? cpu_wdata[4:0] : r_if) | irq_req;
    end
  end

  // IE, DMA source and boot overlay registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_ie      <= 8'd0;
      r_dma_src <= 8'hFF;
      r_boot_en <= 1'b1;
    end else begin
      if (w_cpu_wr && w_sel_ie) begin
        r_ie <= cpu_wdata;
      end
      if (w_cpu_wr && w_sel_dma) begin
        r_dma_src <= cpu_wdata;
      end
      if (w_cpu_wr && w_sel_boot && (cpu_wdata != 8'd0)) begin
        r_boot_en <= 1'b0;
      end
    end
  end

  // HRAM storage; contents are deliberately left uninitialised by reset
  always_ff @(posedge clk_in) begin
    if (w_cpu_wr && w_sel_hram) begin
      r_hram[cpu_addr[6:0]] <= cpu_wdata;
    end
  end

  // Output drive: DMA owns ext_addr only while ACTIVE
  always_comb begin
    cpu_rdata  = r_rdata;
    ext_addr   = w_dma_busy ? {r_dma_src, r_index} : cpu_addr;
    ext_wdata  = cpu_wdata;
    ext_write  = rst_in && w_cpu_wr && w_sel_ext && !w_dma_busy;
    oam_addr   = r_index;
    oam_wdata  = ext_rdata;
    oam_write  = w_dma_busy && mclk_in;
    ie_out     = r_ie;
    if_out     = r_if;
    dma_active = (r_state != DMA_IDLE);
    boot_en    = r_boot_en;
    dma_state  = r_state;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: clock/reset, M-cycle driver task, read-data
// scoreboard queue, external memory model, DMA/OAM monitor, final report.
module tb_mem_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic        mclk_in;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  cpu_rdata;
  logic [15:0] ext_addr;
  logic [7:0]  ext_rdata;
  logic [7:0]  ext_wdata;
  logic        ext_write;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_write;
  logic [4:0]  irq_req;
  logic [7:0]  ie_out;
  logic [4:0]  if_out;
  logic        dma_active;
  logic        boot_en;
  logic [1:0]  dma_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  hram_m [0:126];
  logic [6:0]  addr_list[$];
  int          ext_wr_cnt = 0;
  int          exp_ext_wr = 0;
  logic [15:0] last_ext_addr;
  logic [7:0]  last_ext_wdata;
  int          stray_cnt = 0;
  int          oam_exp = 0;
  logic [7:0]  dma_src_m = 8'h00;

  mem_ctrl dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .mclk_in    (mclk_in),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_write  (cpu_write),
    .cpu_rdata  (cpu_rdata),
    .ext_addr   (ext_addr),
    .ext_rdata  (ext_rdata),
    .ext_wdata  (ext_wdata),
    .ext_write  (ext_write),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_write  (oam_write),
    .irq_req    (irq_req),
    .ie_out     (ie_out),
    .if_out     (if_out),
    .dma_active (dma_active),
    .boot_en    (boot_en),
    .dma_state  (dma_state)
  );

  // Clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // External memory model: byte i at C000+i, a scrambled pattern elsewhere
  function automatic logic [7:0] ext_model(input logic [15:0] a);
    if (a[15:8] == 8'hC0) return a[7:0];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign ext_rdata = ext_model(ext_addr);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One M-cycle: three idle clocks, then one clock with mclk_in=1 carrying
  // the CPU access. When rd_chk is set the expected byte is queued and
  // compared against cpu_rdata after the edge.
  task automatic mcyc(input logic [15:0] a, input logic [7:0] wd, input logic wr,
                      input logic [4:0] irq, input logic rd_chk, input logic [7:0] exp);
    logic [7:0] e;
    repeat (3) begin
      @(negedge clk_in);
      mclk_in = 1'b0; cpu_write = 1'b0; irq_req = 5'd0;
      #1;
      if (ext_write || oam_write) stray_cnt++;
    end
    @(negedge clk_in);
    mclk_in = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_write = wr; irq_req = irq;
    if (rd_chk) exp_q.push_back(exp);
    #1;
    if (ext_write) begin
      ext_wr_cnt++;
      last_ext_addr  = ext_addr;
      last_ext_wdata = ext_wdata;
    end
    if (oam_write) begin
      check_val("oam_addr", {24'd0, oam_addr}, oam_exp);
      check_val("oam_wdata", {24'd0, oam_wdata},
                {24'd0, ext_model({dma_src_m, 8'(oam_exp)})});
      oam_exp++;
    end
    @(posedge clk_in);
    #1;
    if (rd_chk) begin
      e = exp_q.pop_front();
      check_val($sformatf("rd_%04h", a), {24'd0, cpu_rdata}, {24'd0, e});
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    mcyc(a, d, 1'b1, 5'd0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp);
    mcyc(a, 8'h00, 1'b0, 5'd0, 1'b1, exp);
  endtask

  task automatic idle();
    mcyc(16'h0000, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00);
  endtask

  initial begin
    int fall_k;
    logic [6:0] ra;
    logic [7:0] rdv;

    // Reset with a pending forwarded write on the bus: nothing must leak
    rst_in = 1'b0; mclk_in = 1'b1; cpu_write = 1'b1; cpu_addr = 16'hC000;
    cpu_wdata = 8'h11; irq_req = 5'd0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check_val("rst_rdata", {24'd0, cpu_rdata}, 32'hFF);
    check_val("rst_if", {27'd0, if_out}, 32'h0);
    check_val("rst_ie", {24'd0, ie_out}, 32'h0);
    check_val("rst_boot", {31'd0, boot_en}, 32'h1);
    check_val("rst_dma_act", {31'd0, dma_active}, 32'h0);
    check_val("rst_state", {30'd0, dma_state}, 32'h0);
    check_val("rst_ext_wr", {31'd0, ext_write}, 32'h0);
    check_val("rst_oam_wr", {31'd0, oam_write}, 32'h0);
    mclk_in = 1'b0; cpu_write = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;

    // HRAM write/read, no external strobe
    wr(16'hFF85, 8'h5A);
    rd(16'hFF85, 8'h5A);
    check_val("hram_no_ext", ext_wr_cnt, exp_ext_wr);

    // Random HRAM traffic including both boundaries
    addr_list.push_back(7'd0);
    addr_list.push_back(7'd126);
    for (int i = 0; i < 10; i++) addr_list.push_back(7'($urandom_range(0, 126)));
    foreach (addr_list[i]) begin
      ra = addr_list[i];
      rdv = 8'($urandom_range(0, 255));
      hram_m[ra] = rdv;
      wr(16'hFF80 + {9'd0, ra}, rdv);
    end
    foreach (addr_list[i]) begin
      ra = addr_list[i];
      rd(16'hFF80 + {9'd0, ra}, hram_m[ra]);
    end

    // Forwarded read and write
    rd(16'h1234, ext_model(16'h1234));
    rd(16'hFEFF, ext_model(16'hFEFF));
    wr(16'h8000, 8'h77);
    exp_ext_wr++;
    check_val("ext_wr_cnt", ext_wr_cnt, exp_ext_wr);
    check_val("ext_wr_addr", {16'd0, last_ext_addr}, 32'h8000);
    check_val("ext_wr_data", {24'd0, last_ext_wdata}, 32'h77);

    // IE register
    wr(16'hFFFF, 8'hA5);
    rd(16'hFFFF, 8'hA5);
    check_val("ie_out", {24'd0, ie_out}, 32'hA5);

    // IF: request beats a simultaneous CPU clear
    mcyc(16'hFF0F, 8'h00, 1'b1, 5'b00100, 1'b0, 8'h00);
    check_val("if_irq_win", {27'd0, if_out}, 32'h04);
    rd(16'hFF0F, 8'hE4);
    wr(16'hFF0F, 8'h1F);
    rd(16'hFF0F, 8'hFF);
    wr(16'hFF0F, 8'h00);
    rd(16'hFF0F, 8'hE0);

    // Boot overlay: only nonzero writes clear it, and it stays cleared
    rd(16'hFF50, 8'hFF);
    wr(16'hFF50, 8'h00);
    check_val("boot_zero", {31'd0, boot_en}, 32'h1);
    wr(16'hFF50, 8'h01);
    check_val("boot_clr", {31'd0, boot_en}, 32'h0);
    wr(16'hFF50, 8'h00);
    check_val("boot_stay", {31'd0, boot_en}, 32'h0);

    // DMA register reset value, then a full DMA with concurrent CPU traffic
    rd(16'hFF46, 8'hFF);
    dma_src_m = 8'hC0;
    oam_exp = 0;
    wr(16'hFF46, 8'hC0);
    check_val("dma_rise", {31'd0, dma_active}, 32'h1);
    fall_k = -1;
    for (int k = 1; k <= 170; k++) begin
      case (k)
        10: rd(16'hC123, 8'hFF);
        11: wr(16'hC123, 8'hAA);
        12: wr(16'hFFA0, 8'h3C);
        13: rd(16'hFFA0, 8'h3C);
        14: rd(16'hFF46, 8'hC0);
        15: rd(16'hFFFF, 8'hA5);
        default: idle();
      endcase
      if (!dma_active) begin
        fall_k = k;
        break;
      end
    end
    check_val("dma_len", fall_k, 161);
    check_val("oam_count", oam_exp, 160);
    check_val("dma_no_ext", ext_wr_cnt, exp_ext_wr);
    rd(16'hC123, ext_model(16'hC123));

    // Reset in the middle of a DMA at index 80
    oam_exp = 0;
    wr(16'hFF46, 8'hC0);
    for (int k = 0; k < 200 && oam_exp < 80; k++) idle();
    check_val("mid_idx", oam_exp, 80);
    @(negedge clk_in);
    rst_in = 1'b0; mclk_in = 1'b1;
    #1;
    check_val("mid_rst_act", {31'd0, dma_active}, 32'h0);
    check_val("mid_rst_oam", {31'd0, oam_write}, 32'h0);
    check_val("mid_rst_rdata", {24'd0, cpu_rdata}, 32'hFF);
    check_val("mid_rst_boot", {31'd0, boot_en}, 32'h1);
    check_val("mid_rst_ie", {24'd0, ie_out}, 32'h0);
    @(negedge clk_in);
    mclk_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int k = 0; k < 170; k++) idle();
    check_val("post_rst_oam", oam_exp, 80);
    check_val("post_rst_act", {31'd0, dma_active}, 32'h0);
    rd(16'hFF46, 8'hFF);

    check_val("stray_strobes", stray_cnt, 0);
    check_val("ext_wr_total", ext_wr_cnt, exp_ext_wr);
    check_val("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
